// File: rtl/kf_feed_pkg.sv
// ============================================================================
// Module : kf_feed_pkg
// Brief  : Shared types and constants for the Kalman measurement feeder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package kf_feed_pkg;

  localparam int ITER_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } feed_state_e;

endpackage : kf_feed_pkg

`default_nettype wire

// File: rtl/kf_sync_fifo.sv
// ============================================================================
// Module : kf_sync_fifo
// Brief  : Single-clock FIFO with explicit occupancy counter; head reads 0 when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module kf_sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic            full,
  output logic            empty,
  output logic [PTRW:0]   fill
);

  localparam logic [PTRW:0]   C_DEPTH   = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   C_CNT_ONE = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] C_PTR_ONE = PTRW'(1);

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   cnt_q, cnt_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (cnt_q == C_DEPTH);
  assign empty   = (cnt_q == '0);
  assign fill    = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + C_CNT_ONE;
      2'b01:   cnt_d = cnt_q - C_CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the counter alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : kf_sync_fifo

`default_nettype wire

// File: rtl/kf_meas_feeder.sv
// ============================================================================
// Module : kf_meas_feeder
// Brief  : Buffers sensor words and feeds one measurement set per filter iteration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module kf_meas_feeder
  import kf_feed_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3,
  parameter int NMEAS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [W-1:0]      s_data,
  output logic              s_ready,
  input  logic              kf_ready,
  input  logic              kf_take,
  output logic              kf_start,
  output logic [W-1:0]      kf_data,
  output logic              busy,
  output logic [PTRW:0]     fill,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err_underflow,
  output logic              err_extra_take,
  input  logic              clr_err
);

  localparam logic [PTRW:0] C_NMEAS   = (PTRW+1)'(NMEAS);
  localparam logic [PTRW:0] C_CNT_ONE = (PTRW+1)'(1);

  feed_state_e       state_q;
  logic              kf_start_q;
  logic              guard_q;
  logic [PTRW:0]     take_cnt_q;
  logic [PTRW:0]     take_cnt_nxt;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              err_under_q, err_under_d;
  logic              err_extra_q, err_extra_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic in_feed;
  logic take_outside;
  logic take_empty;
  logic iter_done;

  assign s_ready      = !full;
  assign push         = s_valid && !full;
  assign in_feed      = (state_q == FEED);
  assign pop          = kf_take && in_feed && !empty;
  assign take_outside = kf_take && !in_feed;
  assign take_empty   = kf_take && in_feed && empty;
  // The first DRAIN cycle ignores kf_ready so a stale ready cannot end the iteration.
  assign iter_done    = (state_q == DRAIN) && !guard_q && kf_ready;
  assign take_cnt_nxt = take_cnt_q + C_CNT_ONE;

  kf_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .head  (kf_data),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kf_start_q <= 1'b0;
      guard_q    <= 1'b0;
      take_cnt_q <= '0;
    end else begin
      kf_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((fill >= C_NMEAS) && kf_ready) begin
            state_q    <= ISSUE;
            kf_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          take_cnt_q <= '0;
          state_q    <= FEED;
        end
        FEED: begin
          if (kf_take) begin
            take_cnt_q <= take_cnt_nxt;
            if (take_cnt_nxt == C_NMEAS) begin
              state_q <= DRAIN;
              guard_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          guard_q <= 1'b0;
          if (!guard_q && kf_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    iter_cnt_d  = iter_cnt_q;
    err_under_d = err_under_q;
    err_extra_d = err_extra_q;
    if (iter_done)    iter_cnt_d  = iter_cnt_q + ITER_W'(1);
    if (clr_err)      err_under_d = 1'b0;
    if (clr_err)      err_extra_d = 1'b0;
    if (take_empty)   err_under_d = 1'b1;
    if (take_outside) err_extra_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt_q  <= '0;
      err_under_q <= 1'b0;
      err_extra_q <= 1'b0;
    end else begin
      iter_cnt_q  <= iter_cnt_d;
      err_under_q <= err_under_d;
      err_extra_q <= err_extra_d;
    end
  end

  assign kf_start       = kf_start_q;
  assign busy           = (state_q != IDLE);
  assign iter_cnt       = iter_cnt_q;
  assign err_underflow  = err_under_q;
  assign err_extra_take = err_extra_q;

endmodule : kf_meas_feeder

`default_nettype wire

// File: tb/tb_kf_meas_feeder.sv
// ============================================================================
// Module : tb_kf_meas_feeder
// Brief  : Randomized and directed bench for kf_meas_feeder against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_kf_meas_feeder;

  localparam int W     = 24;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;
  localparam int NMEAS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic          kf_ready;
  logic          kf_take;
  logic          kf_start;
  logic [W-1:0]  kf_data;
  logic          busy;
  logic [PTRW:0] fill;
  logic [15:0]   iter_cnt;
  logic          err_underflow;
  logic          err_extra_take;
  logic          clr_err;

  always #5 clk = ~clk;

  kf_meas_feeder #(
    .W(W), .DEPTH(DEPTH), .PTRW(PTRW), .NMEAS(NMEAS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .kf_ready       (kf_ready),
    .kf_take        (kf_take),
    .kf_start       (kf_start),
    .kf_data        (kf_data),
    .busy           (busy),
    .fill           (fill),
    .iter_cnt       (iter_cnt),
    .err_underflow  (err_underflow),
    .err_extra_take (err_extra_take),
    .clr_err        (clr_err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue, the iteration a named phase.
  typedef enum {P_IDLE, P_LAUNCH, P_FEEDING, P_WAITDONE} phase_t;
  logic [W-1:0] q[$];
  phase_t       ph;
  int           takes;
  bit           first_wait;
  logic [15:0]  m_iter;
  bit           m_eu;
  bit           m_ee;

  task automatic model_reset();
    q.delete();
    ph         = P_IDLE;
    takes      = 0;
    first_wait = 1'b0;
    m_iter     = 16'd0;
    m_eu       = 1'b0;
    m_ee       = 1'b0;
  endtask

  task automatic check_outputs(input string w);
    logic [W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({w, ".s_ready"},  s_ready,  (q.size() < DEPTH));
    check({w, ".kf_data"},  kf_data,  head);
    check({w, ".fill"},     fill,     q.size());
    check({w, ".busy"},     busy,     (ph != P_IDLE));
    check({w, ".kf_start"}, kf_start, (ph == P_LAUNCH));
    check({w, ".iter_cnt"}, iter_cnt, m_iter);
    check({w, ".err_uf"},   err_underflow,  m_eu);
    check({w, ".err_xt"},   err_extra_take, m_ee);
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit rdy,
                            input bit take, input bit clr, output bit acc);
    int  n0;
    bit  feeding;
    n0      = q.size();
    feeding = (ph == P_FEEDING);
    acc     = v && (n0 < DEPTH);
    if (clr) begin m_eu = 1'b0; m_ee = 1'b0; end
    if (take && !feeding) m_ee = 1'b1;
    if (take && feeding && n0 == 0) m_eu = 1'b1;
    if (take && feeding && n0 > 0) void'(q.pop_front());
    if (acc) q.push_back(d);
    case (ph)
      P_IDLE:    if (n0 >= NMEAS && rdy) ph = P_LAUNCH;
      P_LAUNCH:  begin takes = 0; ph = P_FEEDING; end
      P_FEEDING: if (take) begin
                   takes++;
                   if (takes == NMEAS) begin ph = P_WAITDONE; first_wait = 1'b1; end
                 end
      P_WAITDONE: if (first_wait) first_wait = 1'b0;
                  else if (rdy) begin m_iter = m_iter + 16'd1; ph = P_IDLE; end
      default:   ph = P_IDLE;
    endcase
  endtask

  // Inputs change at posedge+1; outputs are compared at the following negedge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy,
                       input bit take, input bit clr, output bit acc);
    s_valid  = v;
    s_data   = d;
    kf_ready = rdy;
    kf_take  = take;
    clr_err  = clr;
    @(negedge clk);
    check_outputs("cyc");
    model_step(v, d, rdy, take, clr, acc);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0; kf_take = 1'b0; clr_err = 1'b0; kf_ready = 1'b0; s_data = '0;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_now");
    check("rst_now.kf_start", kf_start, 1'b0);
    @(negedge clk);
    check_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit a;
    int idx;
    logic [W-1:0] words [10];
    rst = 1'b1; s_valid = 1'b0; s_data = '0; kf_ready = 1'b0; kf_take = 1'b0; clr_err = 1'b0;
    #1;
    apply_reset();

    // Two pushes launch an iteration; head walks through both words.
    drive(1, 24'h004000, 1, 0, 0, a);
    drive(1, 24'h00C000, 1, 0, 0, a);
    check("t1.no_start_yet", kf_start, 1'b0);
    check("t1.fill2", fill, 2);
    drive(0, 0, 1, 0, 0, a);
    check("t1.start", kf_start, 1'b1);
    check("t1.head0", kf_data, 24'h004000);
    drive(0, 0, 1, 0, 0, a);
    check("t1.start_once", kf_start, 1'b0);
    drive(0, 0, 1, 1, 0, a);
    check("t1.head1", kf_data, 24'h00C000);
    drive(0, 0, 1, 1, 0, a);
    check("t1.head_empty", kf_data, 0);
    check("t1.drain_busy", busy, 1'b1);
    drive(0, 0, 1, 0, 0, a);
    check("t1.guard", busy, 1'b1);
    drive(0, 0, 1, 0, 0, a);
    check("t1.idle", busy, 1'b0);
    check("t1.iter1", iter_cnt, 1);

    // Back-pressure with sequencer not ready; source holds rejected words.
    apply_reset();
    for (int i = 0; i < 10; i++) words[i] = W'($urandom);
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, words[idx], 0, 0, 0, a);
      if (a) idx++;
    end
    check("t2.fill_full", fill, DEPTH);
    check("t2.s_ready_low", s_ready, 1'b0);
    check("t2.accepted", idx, DEPTH);
    drive(1, words[idx], 1, 0, 0, a);
    drive(1, words[idx], 1, 0, 0, a);
    drive(1, words[idx], 1, 1, 0, a);
    check("t2.fill7", fill, DEPTH - 1);
    check("t2.s_ready_back", s_ready, 1'b1);
    check("t2.head", kf_data, words[1]);

    // Simultaneous push and pop at fill=1 during FEED.
    apply_reset();
    drive(1, 24'h000111, 1, 0, 0, a);
    drive(1, 24'h000222, 1, 0, 0, a);
    drive(0, 0, 1, 0, 0, a);
    drive(0, 0, 1, 0, 0, a);
    drive(0, 0, 1, 1, 0, a);
    drive(1, 24'h000333, 1, 1, 0, a);
    check("t3.fill_same", fill, 1);
    check("t3.head_new", kf_data, 24'h000333);

    // Stray take in IDLE, clear, and error-wins-over-clear.
    apply_reset();
    drive(1, 24'h0ABCDE, 0, 0, 0, a);
    drive(0, 0, 0, 1, 0, a);
    check("t4.fill_kept", fill, 1);
    check("t4.extra_set", err_extra_take, 1'b1);
    drive(0, 0, 0, 0, 1, a);
    check("t4.extra_clr", err_extra_take, 1'b0);
    drive(0, 0, 0, 1, 1, a);
    check("t4.error_wins", err_extra_take, 1'b1);

    // Three full iterations, then reset in the middle of FEED.
    apply_reset();
    for (int it = 0; it < 3; it++) begin
      drive(1, W'($urandom), 1, 0, 0, a);
      drive(1, W'($urandom), 1, 0, 0, a);
      drive(0, 0, 1, 0, 0, a);
      drive(0, 0, 1, 0, 0, a);
      drive(0, 0, 1, 1, 0, a);
      drive(0, 0, 1, 1, 0, a);
      drive(0, 0, 1, 0, 0, a);
      drive(0, 0, 1, 0, 0, a);
    end
    check("t5.iter3", iter_cnt, 3);
    drive(1, W'($urandom), 1, 0, 0, a);
    drive(1, W'($urandom), 1, 0, 0, a);
    drive(0, 0, 1, 0, 0, a);
    drive(0, 0, 1, 0, 0, a);
    check("t5.in_feed", busy, 1'b1);
    apply_reset();
    check("t5.iter_reset", iter_cnt, 0);
    check("t5.fill_reset", fill, 0);

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      else drive($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5, a);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_kf_meas_feeder

`default_nettype wire
